// File: rtl/prbs9_rx_checker.sv
// prbs9_rx_checker: self-synchronising PRBS9 receive checker with lock FSM and bit/error counters.
// Optional feature macro PRBS9_RX_AUTORESYNC_EN: loss of lock returns the FSM to SEED for reacquisition.
//
// state  | meaning
// IDLE   | receiver disabled, counters held, waiting for first valid after enable
// SEED   | shifting 9 received bits into the local generator
// CHECK  | free-running generator compared against rx for one window
// LOCKED | counting bits and errors, monitoring each window for loss
module prbs9_rx_checker #(
    parameter int NB_INPUT   = 8,
    parameter int NB_CNT     = 64,
    parameter int WIN        = 64,
    parameter int LOCK_THR   = 0,
    parameter int UNLOCK_THR = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_enable,
    input  logic                i_valid,
    input  logic [NB_INPUT-1:0] i_sample,
    output logic [1:0]          o_state,
    output logic                o_lock,
    output logic                o_loss,
    output logic [NB_CNT-1:0]   o_bit_count,
    output logic [NB_CNT-1:0]   o_err_count,
    output logic                o_led
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEED   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    localparam int WC_W = $clog2(WIN);
    localparam int WE_W = WC_W + 1;
    localparam logic [WC_W-1:0] WIN_LAST     = WC_W'(WIN - 1);
    localparam logic [31:0]     LOCK_THR_U   = 32'(LOCK_THR);
    localparam logic [31:0]     UNLOCK_THR_U = 32'(UNLOCK_THR);

    state_t            state;
    logic [8:0]        s;
    logic [3:0]        seed_cnt;
    logic [WC_W-1:0]   win_cnt;
    logic [WE_W-1:0]   win_err;
    logic              loss;
    logic [NB_CNT-1:0] bit_count;
    logic [NB_CNT-1:0] err_count;

    logic              rx_bit;
    logic              pred;
    logic              err;
    logic [8:0]        seed_next;
    logic [WE_W-1:0]   win_err_next;
    logic [31:0]       win_err_ext;
    logic              win_end;
    logic              sat;
    logic              unused_sample;

    assign rx_bit        = i_sample[NB_INPUT-1];
    assign unused_sample = ^i_sample[NB_INPUT-2:0];
    assign pred          = s[8] ^ s[4];
    assign err           = rx_bit ^ pred;
    assign seed_next     = {s[7:0], rx_bit};
    assign win_err_next  = win_err + {{(WE_W-1){1'b0}}, err};
    assign win_err_ext   = {{(32-WE_W){1'b0}}, win_err_next};
    assign win_end       = (win_cnt == WIN_LAST);
    assign sat           = &bit_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            s         <= '0;
            seed_cnt  <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            loss      <= 1'b0;
            bit_count <= '0;
            err_count <= '0;
        end else if (!i_enable) begin
            state <= ST_IDLE;
            loss  <= 1'b0;
        end else if (i_valid) begin
            case (state)
                ST_IDLE: begin
                    bit_count <= '0;
                    err_count <= '0;
                    seed_cnt  <= '0;
                    state     <= ST_SEED;
                end
                ST_SEED: begin
                    s <= seed_next;
                    if (seed_cnt == 4'd8) begin
                        seed_cnt <= '0;
                        // an all-zero seed would lock the generator at zero, so keep seeding
                        if (seed_next != 9'd0) begin
                            state   <= ST_CHECK;
                            win_cnt <= '0;
                            win_err <= '0;
                        end
                    end else begin
                        seed_cnt <= seed_cnt + 4'd1;
                    end
                end
                ST_CHECK: begin
                    s <= {s[7:0], pred};
                    if (win_end) begin
                        win_cnt <= '0;
                        win_err <= '0;
                        if (win_err_ext <= LOCK_THR_U) begin
                            state <= ST_LOCKED;
                        end else begin
                            state    <= ST_SEED;
                            seed_cnt <= '0;
                        end
                    end else begin
                        win_cnt <= win_cnt + WC_W'(1);
                        win_err <= win_err_next;
                    end
                end
                ST_LOCKED: begin
                    s <= {s[7:0], pred};
                    if (!sat) begin
                        bit_count <= bit_count + NB_CNT'(1);
                        err_count <= err_count + {{(NB_CNT-1){1'b0}}, err};
                    end
                    if (win_end) begin
                        win_cnt <= '0;
                        win_err <= '0;
                        if (win_err_ext > UNLOCK_THR_U) begin
                            loss <= 1'b1;
`ifdef PRBS9_RX_AUTORESYNC_EN
                            state    <= ST_SEED;
                            seed_cnt <= '0;
`else
                            state    <= ST_LOCKED;
`endif
                        end
                    end else begin
                        win_cnt <= win_cnt + WC_W'(1);
                        win_err <= win_err_next;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_state     = state;
    assign o_lock      = (state == ST_LOCKED) && !loss;
    assign o_led       = o_lock;
    assign o_loss      = loss;
    assign o_bit_count = bit_count;
    assign o_err_count = err_count;

endmodule

// File: tb/tb_prbs9_rx_checker.sv
// Scoreboard bench for prbs9_rx_checker: a WIN=64 instance for lock/error/loss/enable behaviour
// and a narrow WIN=4, 4-bit-counter instance for counter saturation.
`timescale 1ns/1ps
module tb_prbs9_rx_checker;

    localparam logic [4:0] M_ST  = 5'b00001;
    localparam logic [4:0] M_LK  = 5'b00010;
    localparam logic [4:0] M_LS  = 5'b00100;
    localparam logic [4:0] M_BC  = 5'b01000;
    localparam logic [4:0] M_EC  = 5'b10000;
    localparam logic [4:0] M_ALL = 5'b11111;

    typedef struct {
        logic       sel;
        logic [4:0] mask;
        logic [1:0] st;
        logic       lk;
        logic       ls;
        logic [63:0] bc;
        logic [63:0] ec;
        logic [7:0] ph;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        valid;
    logic [7:0]  sample;
    logic        ev;
    logic        ev_q;

    logic [1:0]  m_state;
    logic        m_lock, m_loss, m_led;
    logic [63:0] m_bc, m_ec;
    logic [1:0]  s_state;
    logic        s_lock, s_loss, s_led;
    logic [3:0]  s_bc, s_ec;

    exp_t        exp_q[$];
    int          n_cmp;
    int          n_fail;
    logic [8:0]  g;
    logic [7:0]  phase;

    prbs9_rx_checker dut (
        .clock(clock), .reset(reset), .i_enable(enable), .i_valid(valid), .i_sample(sample),
        .o_state(m_state), .o_lock(m_lock), .o_loss(m_loss),
        .o_bit_count(m_bc), .o_err_count(m_ec), .o_led(m_led)
    );

    prbs9_rx_checker #(.NB_INPUT(8), .NB_CNT(4), .WIN(4), .LOCK_THR(0), .UNLOCK_THR(8)) dut_small (
        .clock(clock), .reset(reset), .i_enable(enable), .i_valid(valid), .i_sample(sample),
        .o_state(s_state), .o_lock(s_lock), .o_loss(s_loss),
        .o_bit_count(s_bc), .o_err_count(s_ec), .o_led(s_led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) ev_q <= ev;

    function automatic exp_t mk(input logic sel, input logic [4:0] mask, input logic [1:0] st,
                                input logic lk, input logic ls, input logic [63:0] bc,
                                input logic [63:0] ec);
        exp_t e;
        e.sel = sel; e.mask = mask; e.st = st; e.lk = lk; e.ls = ls;
        e.bc = bc; e.ec = ec; e.ph = phase;
        return e;
    endfunction

    task automatic cmp(input string name, input logic [7:0] ph, input logic [63:0] act,
                       input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s (phase %0d): got %0d, required %0d", name, ph, act, expv);
        end
    endtask

    // monitor: the DUT presents a result on the negedge after any stimulus cycle flagged with ev
    initial begin
        exp_t        e;
        logic [1:0]  a_st;
        logic        a_lk, a_ls, a_led;
        logic [63:0] a_bc, a_ec;
        forever begin
            @(negedge clock);
            if (ev_q) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: got empty queue, required an entry");
                end else begin
                    e = exp_q.pop_front();
                    if (e.sel) begin
                        a_st = s_state; a_lk = s_lock; a_ls = s_loss; a_led = s_led;
                        a_bc = {60'd0, s_bc}; a_ec = {60'd0, s_ec};
                    end else begin
                        a_st = m_state; a_lk = m_lock; a_ls = m_loss; a_led = m_led;
                        a_bc = m_bc; a_ec = m_ec;
                    end
                    if (e.mask[0]) cmp("state", e.ph, {62'd0, a_st}, {62'd0, e.st});
                    if (e.mask[1]) begin
                        cmp("lock", e.ph, {63'd0, a_lk}, {63'd0, e.lk});
                        cmp("led", e.ph, {63'd0, a_led}, {63'd0, e.lk});
                    end
                    if (e.mask[2]) cmp("loss", e.ph, {63'd0, a_ls}, {63'd0, e.ls});
                    if (e.mask[3]) cmp("bit_count", e.ph, a_bc, e.bc);
                    if (e.mask[4]) cmp("err_count", e.ph, a_ec, e.ec);
                end
            end
        end
    end

    task automatic tick(input logic vld, input logic [7:0] smp, input logic evt);
        valid = vld; sample = smp; ev = evt;
        @(posedge clock);
        #1;
        valid = 1'b0; ev = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, sample, 1'b0);
    endtask

    task automatic send(input logic inv, input int per, input exp_t e);
        logic b;
        b = g[8] ^ g[4];
        g = {g[7:0], b};
        exp_q.push_back(e);
        tick(1'b1, (b ^ inv) ? 8'h80 : 8'h7F, 1'b1);
        gap(per - 1);
    endtask

    task automatic send_raw(input logic [7:0] smp, input int per, input exp_t e);
        exp_q.push_back(e);
        tick(1'b1, smp, 1'b1);
        gap(per - 1);
    endtask

    // IDLE valid, 9 seed valids, win check valids; counters read zero throughout
    task automatic acquire(input logic sel, input int win, input int per);
        send(1'b0, per, mk(sel, M_ALL, 2'd1, 1'b0, 1'b0, 64'd0, 64'd0));
        for (int i = 1; i <= 9; i++)
            send(1'b0, per, mk(sel, M_ALL, (i < 9) ? 2'd1 : 2'd2, 1'b0, 1'b0, 64'd0, 64'd0));
        for (int i = 1; i <= win; i++)
            send(1'b0, per, mk(sel, M_ALL, (i < win) ? 2'd2 : 2'd3, (i == win), 1'b0, 64'd0, 64'd0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of stimulus, required finish before 2 ms");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_fail = 0;
        g = 9'b110101010;
        reset = 1'b1; enable = 1'b0; valid = 1'b0; sample = 8'h00; ev = 1'b0; ev_q = 1'b0;
        phase = 8'd0;
        @(posedge clock);
        #1;
        gap(3);
        exp_q.push_back(mk(1'b0, M_ALL, 2'd0, 1'b0, 1'b0, 64'd0, 64'd0));
        tick(1'b0, 8'h00, 1'b1);
        reset = 1'b0;

        // clean acquisition then 10000 locked symbols
        phase = 8'd1;
        enable = 1'b1;
        acquire(1'b0, 64, 4);
        for (int k = 1; k <= 10000; k++)
            send(1'b0, 2, mk(1'b0, M_ALL, 2'd3, 1'b1, 1'b0, 64'(k), 64'd0));

        // disable holds counters; disable beats valid; re-enable clears
        phase = 8'd2;
        enable = 1'b0;
        exp_q.push_back(mk(1'b0, M_ALL, 2'd0, 1'b0, 1'b0, 64'd10000, 64'd0));
        tick(1'b0, 8'h80, 1'b1);
        exp_q.push_back(mk(1'b0, M_ALL, 2'd0, 1'b0, 1'b0, 64'd10000, 64'd0));
        tick(1'b1, 8'h80, 1'b1);
        enable = 1'b1;
        gap(3);
        acquire(1'b0, 64, 4);

        // one inverted bit every 100 symbols
        phase = 8'd3;
        for (int k = 0; k < 10000; k++)
            send((k % 100) == 99, 2,
                 mk(1'b0, M_ALL, 2'd3, 1'b1, 1'b0, 64'(k + 1), 64'((k + 1) / 100)));

        // 16-bit burst inside one window; window closes at the 48th symbol here
        phase = 8'd4;
        for (int j = 0; j < 48; j++) begin
            int ne;
            ne = (j < 8) ? 0 : ((j - 7 > 16) ? 16 : j - 7);
            if (j < 47)
                send(j >= 8 && j < 24, 2,
                     mk(1'b0, M_ALL, 2'd3, 1'b1, 1'b0, 64'(10001 + j), 64'(100 + ne)));
            else
`ifdef PRBS9_RX_AUTORESYNC_EN
                send(1'b0, 2, mk(1'b0, M_ALL, 2'd1, 1'b0, 1'b1, 64'd10048, 64'd116));
`else
                send(1'b0, 2, mk(1'b0, M_ALL, 2'd3, 1'b0, 1'b1, 64'd10048, 64'd116));
`endif
        end
        phase = 8'd5;
`ifdef PRBS9_RX_AUTORESYNC_EN
        for (int i = 1; i <= 9; i++)
            send(1'b0, 2, mk(1'b0, M_ALL, (i < 9) ? 2'd1 : 2'd2, 1'b0, 1'b1, 64'd10048, 64'd116));
        for (int i = 1; i <= 64; i++)
            send(1'b0, 2, mk(1'b0, M_ALL, (i < 64) ? 2'd2 : 2'd3, 1'b0, 1'b1, 64'd10048, 64'd116));
        send(1'b0, 2, mk(1'b0, M_ALL, 2'd3, 1'b0, 1'b1, 64'd10049, 64'd116));
`else
        for (int i = 1; i <= 4; i++)
            send(1'b0, 2, mk(1'b0, M_ALL, 2'd3, 1'b0, 1'b1, 64'(10048 + i), 64'd116));
`endif

        // reset mid-LOCKED together with a valid
        phase = 8'd6;
        reset = 1'b1;
        exp_q.push_back(mk(1'b0, M_ALL, 2'd0, 1'b0, 1'b0, 64'd0, 64'd0));
        tick(1'b1, 8'h80, 1'b1);
        reset = 1'b0;
        exp_q.push_back(mk(1'b0, M_ALL, 2'd0, 1'b0, 1'b0, 64'd0, 64'd0));
        tick(1'b0, 8'h80, 1'b1);

        // all-zero input never leaves SEED
        phase = 8'd7;
        send_raw(8'h00, 4, mk(1'b0, M_ALL, 2'd1, 1'b0, 1'b0, 64'd0, 64'd0));
        for (int i = 1; i <= 30; i++)
            send_raw(8'h00, 4, mk(1'b0, M_ALL, 2'd1, 1'b0, 1'b0, 64'd0, 64'd0));

        // narrow instance: counters freeze once bit_count is all-ones
        phase = 8'd8;
        reset = 1'b1;
        exp_q.push_back(mk(1'b1, M_ALL, 2'd0, 1'b0, 1'b0, 64'd0, 64'd0));
        tick(1'b0, 8'h80, 1'b1);
        reset = 1'b0;
        acquire(1'b1, 4, 2);
        for (int k = 1; k <= 20; k++)
            send(k == 10 || k >= 16, 2,
                 mk(1'b1, M_ALL, 2'd3, 1'b1, 1'b0, 64'((k < 15) ? k : 15), 64'((k >= 10) ? 1 : 0)));

        gap(4);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs9_rx_checker.md
# prbs9_rx_checker

Self-synchronising PRBS9 receiver and checker for the receive end of the PRBS9 → polyphase filter → downsampler chain. It takes the symbol-rate downsampled filter output and slices it to one bit per symbol. It seeds a local PRBS9 generator from the received bits, runs an acquisition state machine to declare lock, and then counts received bits and bit errors. It replaces manual delay search; lock status drives a board LED.

## Interface
Parameters:
- NB_INPUT, 8, width of input sample
- NB_CNT, 64, width of bit/error counters
- WIN, 64, acquisition/monitor window length in symbols; power of two, 4..1024
- LOCK_THR, 0, max errors in one CHECK window to declare lock
- UNLOCK_THR, 8, errors in one LOCKED window above which lock is lost

Ports:
- clock  in  1  system clock (oversampled rate)
- reset  in  1  reset, synchronous, active-high
- i_enable  in  1  receiver enable (board switch)
- i_valid  in  1  one-cycle strobe, one per symbol (T)
- i_sample  in  NB_INPUT  signed downsampled sample; rx bit = i_sample[NB_INPUT-1]
- o_state  out  2  FSM state: 0 IDLE, 1 SEED, 2 CHECK, 3 LOCKED
- o_lock  out  1  locked and no loss flagged
- o_loss  out  1  sticky loss-of-lock flag
- o_bit_count  out  NB_CNT  symbols checked while locked
- o_err_count  out  NB_CNT  errors counted while locked
- o_led  out  1  equals o_lock

## Operation
- Local generator: 9-bit register s; predicted bit p = s[8]^s[4]; advance s <= {s[7:0], p}.
- Rx bit r = i_sample[NB_INPUT-1]; error = r ^ p.
- All state changes occur only on cycles with i_valid=1, except enable/reset.
- IDLE: entered from any state on the edge after i_enable=0. Counters hold their values. o_loss clears. When i_enable=1 and i_valid=1: counters clear, seed count clears, go to SEED.
- SEED: each valid does s <= {s[7:0], r}. After 9 valids:
  - all-zero seed → stay in SEED and restart the seed count;
  - otherwise → CHECK, with window counters cleared.
- CHECK: each valid, advance s (predicted bit, not r) and accumulate window errors. At the WIN-th valid:
  - window errors ≤ LOCK_THR → LOCKED;
  - else → SEED.
- LOCKED: each valid, advance s, bit_count+1, err_count+error. Window errors restart every WIN valids. When a window ends with errors > UNLOCK_THR, o_loss <= 1 and:
  - with the macro, go to SEED (see Configuration);
  - without it, stay in LOCKED.
- Saturation: once o_bit_count reaches all-ones, both counters freeze.
- o_lock = (state==LOCKED) & ~o_loss.
- Simultaneous events: reset beats everything; i_enable=0 beats i_valid.

## Timing
- Reset value: every output 0, state IDLE, s=0, all internal counters 0.
- Outputs are registered. A valid at edge k is reflected in the counters and o_state after edge k.
- Minimum acquisition: 1 valid (IDLE→SEED) + 9 seed valids + WIN check valids. o_lock rises after the edge of the WIN-th CHECK valid.
- Loss decision occurs only at a window boundary. Worst-case detection latency is 2·WIN valids.
- Reset mid-operation: the next edge returns the block to full reset values, including the counters.

## Configuration
- PRBS9_RX_AUTORESYNC_EN defined:
  - loss of lock sends the FSM to SEED;
  - the counters keep their values;
  - o_loss stays set until IDLE or reset;
  - o_lock may reassert after relock only once IDLE clears o_loss.
- Not defined:
  - the FSM stays in LOCKED and counting continues;
  - o_lock stays 0 until i_enable is cycled or reset.

## Test plan
- Clean lock: PRBS9 bits (seed 9'b110101010) mapped to samples 8'h80 for 1 and 8'h7F for 0, i_valid every 4th clock, WIN=64.
  - Expect o_state 1→2→3 and o_lock=1 after valid #74.
  - After 10000 locked valids: o_err_count=0, o_bit_count=10000.
- Sparse errors: after lock, invert 1 bit every 100 symbols for 10000 symbols.
  - Expect o_err_count=100, o_bit_count=10000, o_lock stays 1.
- Burst loss: after lock, invert 16 consecutive bits.
  - With the macro: o_loss=1, FSM returns to SEED, relocks to state 3, o_lock=0.
  - Without it: o_loss=1, o_lock=0, state stays 3.
- All-zero input (samples 8'h00):
  - FSM cycles SEED with zero seed and never enters CHECK; o_lock=0.
- Enable/reset:
  - i_enable=0 while locked → IDLE next edge with counters held; re-enable clears the counters.
  - Reset asserted mid-LOCKED → all outputs 0 after one edge.
